// File: rtl/toggle_cover_pkg.sv
// ============================================================================
// Module      : toggle_cover_pkg
// Description : Shared types and constants for the toggle-coverage detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package toggle_cover_pkg;

    // Lane offset of the rise/fall strobe within each per-bit pair
    localparam int RISE_OFS = 0;
    localparam int FALL_OFS = 1;

    typedef enum logic [0:0] {
        ARM_WARMUP = 1'b0,
        ARM_LIVE   = 1'b1
    } arm_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/toggle_cover_detector_if.sv
// ============================================================================
// Module      : toggle_cover_detector_if
// Description : Sample/strobe bundle between a design monitor and the detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface toggle_cover_detector_if
    import toggle_cover_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = cnt_width(2 * WIDTH)
);
    logic                 en;
    logic                 clear;
    logic [WIDTH-1:0]     sig;
    logic [2*WIDTH-1:0]   valid;
    logic [CNT_W-1:0]     covered_cnt;
    logic                 all_covered;

    modport master (
        output en, clear, sig,
        input  valid, covered_cnt, all_covered
    );

    modport slave (
        input  en, clear, sig,
        output valid, covered_cnt, all_covered
    );
endinterface

`default_nettype wire

// File: rtl/toggle_cover_popcount.sv
// ============================================================================
// Module      : toggle_cover_popcount
// Description : Combinational population count of an N-bit vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_cover_popcount #(
    parameter int N   = 20,
    parameter int W   = $clog2(N + 1)
) (
    input  wire logic [N-1:0] i_bits,
    output logic      [W-1:0] o_count
);
    logic [W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = w_sum + W'(i_bits[k]);
        end
    end

    assign o_count = w_sum;
endmodule

`default_nettype wire

// File: rtl/toggle_cover_detector.sv
// ============================================================================
// Module      : toggle_cover_detector
// Description : First-occurrence rise/fall strobes per signal bit, deduplicated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_cover_detector
    import toggle_cover_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = cnt_width(2 * WIDTH)
) (
    input  wire logic           clock,
    input  wire logic           reset,
    toggle_cover_detector_if.slave bus
);
    localparam int NPTS = 2 * WIDTH;

    arm_state_t         r_arm_state;
    arm_state_t         w_arm_next;
    logic [WIDTH-1:0]   r_prev;
    logic [NPTS-1:0]    r_seen;
    logic [NPTS-1:0]    r_valid;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_all;
    logic [NPTS-1:0]    w_hit;
    logic [NPTS-1:0]    w_new;
    logic [CNT_W-1:0]   w_pop;
    logic               w_sample;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign w_hit[2*i+RISE_OFS] = ~r_prev[i] &  bus.sig[i];
        assign w_hit[2*i+FALL_OFS] =  r_prev[i] & ~bus.sig[i];
    end

    // The warm-up sample never compares against stale or reset prev
    assign w_sample = bus.en & ~bus.clear & (r_arm_state == ARM_LIVE);
    assign w_new    = w_sample ? (w_hit & ~r_seen) : '0;

    toggle_cover_popcount #(
        .N (NPTS),
        .W (CNT_W)
    ) u_popcount (
        .i_bits  (w_new),
        .o_count (w_pop)
    );

    always_comb begin
        w_arm_next = r_arm_state;
        if (bus.clear) begin
            w_arm_next = ARM_WARMUP;
        end else if (bus.en) begin
            w_arm_next = ARM_LIVE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_arm_state <= ARM_WARMUP;
            r_prev      <= '0;
            r_seen      <= '0;
            r_valid     <= '0;
            r_cnt       <= '0;
            r_all       <= 1'b0;
        end else begin
            r_arm_state <= w_arm_next;
            if (bus.en) begin
                r_prev <= bus.sig;
            end
            if (bus.clear) begin
                r_seen  <= '0;
                r_valid <= '0;
                r_cnt   <= '0;
                r_all   <= 1'b0;
            end else begin
                r_seen  <= r_seen | w_new;
                r_valid <= w_new;
                r_cnt   <= r_cnt + w_pop;
                r_all   <= (r_cnt == CNT_W'(NPTS));
            end
        end
    end

    assign bus.valid       = r_valid;
    assign bus.covered_cnt = r_cnt;
    assign bus.all_covered = r_all;
endmodule

`default_nettype wire

// File: tb/tb_toggle_cover_detector.sv
// ============================================================================
// Module      : tb_toggle_cover_detector
// Description : Directed self-checking bench for toggle_cover_detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toggle_cover_detector;
    localparam int WIDTH = 10;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;

    toggle_cover_detector_if #(.WIDTH(WIDTH)) bus ();

    toggle_cover_detector #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle just after it
    task automatic step(input logic en, input logic clr, input logic [WIDTH-1:0] s);
        bus.en    = en;
        bus.clear = clr;
        bus.sig   = s;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [19:0] v, input logic [4:0] c, input logic a);
        check({tag, ".valid"}, 32'(bus.valid), 32'(v));
        check({tag, ".cnt"},   32'(bus.covered_cnt), 32'(c));
        check({tag, ".all"},   32'(bus.all_covered), 32'(a));
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        bus.en    = 1'b0;
        bus.clear = 1'b0;
        bus.sig   = '0;
        #12;
        expect_out("reset", 20'h0, 5'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // Single bit rise then fall, each strobed exactly once
        step(1'b1, 1'b0, 10'h000);
        expect_out("warm0", 20'h0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 10'h000);
        expect_out("idle0", 20'h0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 10'h001);
        expect_out("rise0", 20'h00001, 5'd1, 1'b0);
        step(1'b1, 1'b0, 10'h001);
        expect_out("rise0_once", 20'h0, 5'd1, 1'b0);
        step(1'b1, 1'b0, 10'h000);
        expect_out("fall0", 20'h00002, 5'd2, 1'b0);
        step(1'b1, 1'b0, 10'h001);
        expect_out("rise0_dup", 20'h0, 5'd2, 1'b0);
        step(1'b1, 1'b0, 10'h000);
        expect_out("fall0_dup", 20'h0, 5'd2, 1'b0);

        // Fresh reset: warm-up on all-ones, then full coverage
        @(negedge clock);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step(1'b1, 1'b0, 10'h3FF);
        expect_out("warm_ones", 20'h0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 10'h000);
        expect_out("all_fall", 20'hAAAAA, 5'd10, 1'b0);
        step(1'b1, 1'b0, 10'h3FF);
        expect_out("all_rise", 20'h55555, 5'd20, 1'b0);
        step(1'b1, 1'b0, 10'h3FF);
        expect_out("all_cov", 20'h0, 5'd20, 1'b1);
        step(1'b1, 1'b0, 10'h000);
        expect_out("saturated", 20'h0, 5'd20, 1'b1);

        // Clear with a simultaneous change, then re-arm
        step(1'b1, 1'b1, 10'h004);
        expect_out("clear", 20'h0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 10'h000);
        expect_out("rearm", 20'h0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 10'h004);
        expect_out("rise2", 20'h00010, 5'd1, 1'b0);

        // Disabled sampling hides toggles and holds prev
        step(1'b0, 1'b0, 10'h005);
        expect_out("dis_a", 20'h0, 5'd1, 1'b0);
        step(1'b0, 1'b0, 10'h004);
        expect_out("dis_b", 20'h0, 5'd1, 1'b0);
        step(1'b0, 1'b0, 10'h005);
        expect_out("dis_c", 20'h0, 5'd1, 1'b0);
        step(1'b1, 1'b0, 10'h005);
        expect_out("reen_rise", 20'h00001, 5'd2, 1'b0);

        // Async reset while a strobe is live
        step(1'b1, 1'b0, 10'h004);
        expect_out("pre_async", 20'h00002, 5'd3, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        expect_out("async", 20'h0, 5'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 1'b0, 10'h3FF);
        expect_out("post_warm", 20'h0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 10'h3FE);
        expect_out("post_fall", 20'h00002, 5'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
